mod3_serial_driver: RTL and testbench
=====================================

Name: mod3_serial_driver

Overview:
- Transmit side of the serial multiple-of-3 detector link.
- Accepts a parallel word through a valid/ready handshake and pulses the detector reset.
- Shifts the selected bit field out MSB-first, one bit per clock, on x.
- Captures the detector's per-bit out response into a trace register and reports the final verdict with a one-cycle done pulse.

Parameters:
- WIDTH, 32, maximum frame length in bits; also the width of data_in and trace.
- LEN_W, 6, width of len_in; must satisfy 2^LEN_W > WIDTH.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- load_valid  in  1  frame request.
- load_ready  out  1  high only in IDLE; a frame is accepted on an edge where load_valid && load_ready.
- data_in  in  WIDTH  frame bits; active field is data_in[L-1:0].
- len_in  in  LEN_W  frame length L; 0 or >WIDTH means WIDTH.
- x  out  1  serial bit to the detector, registered.
- det_rst  out  1  reset pulse to the detector, registered.
- det_out  in  1  detector Moore output.
- done  out  1  one-cycle frame-complete pulse.
- result  out  1  det_out for the final bit; valid from done until the next acceptance.
- trace  out  WIDTH  per-bit detector responses; first bit in trace[L-1], last bit in trace[0]; bits above L-1 are 0.
- mismatch  out  1  self-check flag; constant 0 when the optional feature is excluded.

Behaviour:
- Reset values: state IDLE; x=0, det_rst=0, done=0, result=0, trace=0, mismatch=0; load_ready=1 combinationally once out of reset.
- Reset asserted mid-frame aborts immediately; all outputs return to their reset values and no done pulse is issued.
- IDLE: load_ready=1.
  - On acceptance, latch data_in into the shift register, latch L, clear trace and mismatch, and go to RSTDET.
  - load_valid in any other state is ignored.
- RSTDET (1 cycle): det_rst=1, x=0. Next state SHIFT, bit counter k=0.
- SHIFT (L cycles): x = bit L-1-k of the latched word.
  - The detector samples x at the closing edge of each cycle.
  - At each closing edge with k>=1, det_out (response to bit k-1) is shifted into trace.
  - k increments each cycle; after k=L-1, go to CAPTURE.
- CAPTURE (1 cycle): x=0. At its closing edge, det_out (response to bit L-1) is shifted into trace and copied into result. Go to DONE.
- DONE (1 cycle): done=1. Go to IDLE.
- Latency: done is high during the cycle beginning L+2 edges after the accepting edge. Back-to-back frames are accepted no sooner than the cycle after DONE.
- Trace shifting: trace <= {trace[WIDTH-2:0], det_out}. After L captures, the first response sits at trace[L-1].
- L=1: SHIFT lasts one cycle with no capture; CAPTURE supplies the only bit.
- det_rst is never high outside RSTDET.

Optional Feature:
MOD3_SELFCHECK_EN
- Defined:
  - An internal residue r (2 bits) is cleared in RSTDET and updated r <= (2r + x) mod 3 at each SHIFT edge.
  - A one-deep pipeline of the expected value (r==0) is aligned with every trace capture.
  - Any capture where det_out differs from the expected value sets mismatch, which stays high until the next acceptance or reset.
  - When done is high, mismatch reflects the whole frame.
- Not defined: no residue logic; mismatch tied to 0.
- All other behaviour is identical in both builds.

Test Plan:
1. Bench connects an ideal Moore mod-3 detector model. Send L=8, data 8'b10010011 (147).
   - Required: done after 10 edges, result=1, trace=32'h0000001D, mismatch=0.
2. Send L=16, data 16'hBBE4 (48100).
   - Required: result=0, trace[15:0] matches the prefix-residue model, trace[31:16]=0.
3. Send L=3, data 32'hFFFFFFFF.
   - Required: bits 1,1,1 transmitted; trace=32'h2; result=0.
   - Then L=0: 32 bits transmitted, result=1 (2^32-1 mod 3 = 0).
4. Hold load_valid high with new data throughout frame 1.
   - Required: load_ready=0 from acceptance until after DONE; second frame starts only from IDLE.
   - det_rst is high for exactly 1 cycle per frame.
5. Assert rst during SHIFT of a 16-bit frame.
   - Required: outputs are at reset values within the same cycle, and no done pulse occurs.
   - A subsequent frame completes correctly.
6. With MOD3_SELFCHECK_EN defined, the detector model inverts its output on the 5th bit.
   - Required: mismatch=1 at done and cleared at the next acceptance.
   - Without the macro, mismatch stays 0.

Source files
------------

// File: rtl/mod3_serial_driver.sv
// mod3_serial_driver: transmit side of the serial multiple-of-3 detector link.
// Accepts a parallel frame over valid/ready and pulses the detector reset.
// Shifts the selected field out MSB-first on x, one bit per clock.
// Records the detector's per-bit response in trace and reports the final
// verdict in result, alongside a one-cycle done pulse.
// Optional build macro MOD3_SELFCHECK_EN adds an internal residue tracker.
// When the macro is defined, any disagreement with the detector raises mismatch.
module mod3_serial_driver #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [LEN_W-1:0] len_in,
    output logic             x,
    output logic             det_rst,
    input  logic             det_out,
    output logic             done,
    output logic             result,
    output logic [WIDTH-1:0] trace,
    output logic             mismatch
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RSTDET,
        S_SHIFT,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [LEN_W-1:0] WLEN = LEN_W'(WIDTH);

    // Zero or out-of-range lengths select the full word width.
    function automatic logic [LEN_W-1:0] f_norm_len(input logic [LEN_W-1:0] len);
        if (len == '0 || len > WLEN) return WLEN;
        return len;
    endfunction

    state_t           r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_k;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_trace;
    logic             r_x;
    logic             r_det_rst;
    logic             r_done;
    logic             r_result;

    logic [LEN_W-1:0] w_len;
    logic             w_accept;
    logic             w_capture;

    assign w_len      = f_norm_len(len_in);
    assign w_accept   = load_valid && (r_state == S_IDLE);
    // The response to bit k-1 is visible while bit k is on the wire, so the
    // first SHIFT cycle has nothing to capture and CAPTURE supplies the last.
    assign w_capture  = ((r_state == S_SHIFT) && (r_k != '0)) || (r_state == S_CAPTURE);

    assign load_ready = (r_state == S_IDLE);
    assign x          = r_x;
    assign det_rst    = r_det_rst;
    assign done       = r_done;
    assign result     = r_result;
    assign trace      = r_trace;

    // Frame shift register: the active field is left-aligned so bit L-1 leaves first.
    always_ff @(posedge clk) begin
        if (w_accept)
            r_shift <= data_in << (WLEN - w_len);
        else if (r_state == S_RSTDET || r_state == S_SHIFT)
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
    end

    // Frame sequencer with registered serial, reset and completion outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_k       <= '0;
            r_x       <= 1'b0;
            r_det_rst <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= 1'b0;
            r_trace   <= '0;
        end else begin
            r_det_rst <= 1'b0;
            r_done    <= 1'b0;
            if (w_capture)
                r_trace <= {r_trace[WIDTH-2:0], det_out};
            case (r_state)
                S_IDLE: begin
                    if (load_valid) begin
                        r_len     <= w_len;
                        r_trace   <= '0;
                        r_x       <= 1'b0;
                        r_det_rst <= 1'b1;
                        r_state   <= S_RSTDET;
                    end
                end
                S_RSTDET: begin
                    r_k     <= '0;
                    r_x     <= r_shift[WIDTH-1];
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_k == r_len - LEN_W'(1)) begin
                        r_x     <= 1'b0;
                        r_state <= S_CAPTURE;
                    end else begin
                        r_k <= r_k + LEN_W'(1);
                        r_x <= r_shift[WIDTH-1];
                    end
                end
                S_CAPTURE: begin
                    r_result <= det_out;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MOD3_SELFCHECK_EN
    // Residue update: appending bit b to a number with residue r gives (2r+b) mod 3.
    function automatic logic [1:0] f_res_next(input logic [1:0] r, input logic b);
        logic [2:0] s;
        s = {r, 1'b0} + {2'b00, b};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    logic [1:0] r_res;
    logic       r_exp;
    logic       r_mismatch;
    logic [1:0] w_res_next;

    assign w_res_next = f_res_next(r_res, r_x);
    assign mismatch   = r_mismatch;

    // Track the prefix residue and hold the expected response until it is captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res      <= '0;
            r_exp      <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            if (w_accept)
                r_mismatch <= 1'b0;
            if (r_state == S_RSTDET)
                r_res <= '0;
            if (r_state == S_SHIFT) begin
                r_res <= w_res_next;
                r_exp <= (w_res_next == 2'd0);
            end
            if (w_capture && (det_out != r_exp))
                r_mismatch <= 1'b1;
        end
    end
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_mod3_serial_driver.sv
// Directed bench for mod3_serial_driver with an ideal Moore mod-3 detector
// model attached; the model can corrupt its 5th response on request.
module tb_mod3_serial_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] data_in;
    logic [5:0]  len_in;
    logic        x;
    logic        det_rst;
    logic        det_out;
    logic        done;
    logic        result;
    logic [31:0] trace;
    logic        mismatch;

    int total = 0;
    int bad   = 0;

`ifdef MOD3_SELFCHECK_EN
    localparam logic MIS_EXP = 1'b1;
`else
    localparam logic MIS_EXP = 1'b0;
`endif

    mod3_serial_driver #(.WIDTH(32), .LEN_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .data_in    (data_in),
        .len_in     (len_in),
        .x          (x),
        .det_rst    (det_rst),
        .det_out    (det_out),
        .done       (done),
        .result     (result),
        .trace      (trace),
        .mismatch   (mismatch)
    );

    always #5 clk = ~clk;

    // Ideal detector: residue state, output high when residue is zero.
    logic [1:0] m_st;
    int         m_cnt;
    logic       inv_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st  <= 2'd0;
            m_cnt <= 0;
        end else if (det_rst) begin
            m_st  <= 2'd0;
            m_cnt <= 0;
        end else begin
            case ({m_st, x})
                3'b000: m_st <= 2'd0;
                3'b001: m_st <= 2'd1;
                3'b010: m_st <= 2'd2;
                3'b011: m_st <= 2'd0;
                3'b100: m_st <= 2'd1;
                3'b101: m_st <= 2'd2;
                default: m_st <= 2'd0;
            endcase
            m_cnt <= m_cnt + 1;
        end
    end

    assign det_out = (m_st == 2'd0) ^ (inv_en && (m_cnt == 5));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int w;
        w = 0;
        while (!load_ready && w < 60) begin
            @(posedge clk); #1;
            w++;
        end
        chk({tag, "_idle"}, load_ready, 1'b1);
    endtask

    // Send one frame and check transmission, latency and final outputs.
    task automatic send(input string tag, input logic [5:0] lcode, input logic [31:0] data,
                        input int L, input logic [31:0] exp_trace, input logic exp_res,
                        input logic exp_mis);
        int n;
        logic [31:0] xs;
        logic [31:0] mask;
        wait_idle(tag);
        load_valid = 1'b1;
        data_in    = data;
        len_in     = lcode;
        @(posedge clk); #1;
        load_valid = 1'b0;
        chk({tag, "_detrst"}, det_rst, 1'b1);
        chk({tag, "_busy"}, load_ready, 1'b0);
        chk({tag, "_mis_clr"}, mismatch, 1'b0);
        n  = 0;
        xs = '0;
        while (!done && n < L + 10) begin
            @(posedge clk); #1;
            n++;
            if (n <= L) xs = {xs[30:0], x};
        end
        mask = (L >= 32) ? 32'hFFFF_FFFF : ((32'd1 << L) - 32'd1);
        chk({tag, "_latency"}, n, L + 2);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_bits"}, xs, data & mask);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_trace"}, trace, exp_trace);
        chk({tag, "_mismatch"}, mismatch, exp_mis);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_ready_after"}, load_ready, 1'b1);
    endtask

    int n1, n2, first_ready, rst_cnt, done_cnt;

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        data_in    = '0;
        len_in     = '0;
        inv_en     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_x", x, 1'b0);
        chk("rst_detrst", det_rst, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 1'b0);
        chk("rst_trace", trace, 32'h0);
        chk("rst_mismatch", mismatch, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", load_ready, 1'b1);

        // 147 = 10010011: responses 0,0,0,1,1,1,0,1.
        send("f147", 6'd8, 32'h0000_0093, 8, 32'h0000_001D, 1'b1, 1'b0);
        // 0xBBE4: prefix residues 1,2,2,2,2,1,0,1,0,1,0,0,0,1,2,1.
        send("fBBE4", 6'd16, 32'h0000_BBE4, 16, 32'h0000_02B8, 1'b0, 1'b0);
        // Three ones: residues 1,0,1.
        send("f3ones", 6'd3, 32'hFFFF_FFFF, 3, 32'h0000_0002, 1'b0, 1'b0);
        // Full width of ones: odd-indexed prefixes are multiples of 3.
        send("f32ones", 6'd0, 32'hFFFF_FFFF, 32, 32'h5555_5555, 1'b1, 1'b0);

        // load_valid held through frame 1; frame 2 (1100) waits for IDLE.
        wait_idle("hold");
        load_valid = 1'b1;
        data_in    = 32'h0000_0093;
        len_in     = 6'd8;
        @(posedge clk); #1;
        data_in = 32'h0000_000C;
        len_in  = 6'd4;
        chk("hold_busy0", load_ready, 1'b0);
        n1 = -1; n2 = -1; first_ready = -1;
        rst_cnt = det_rst ? 1 : 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (det_rst) rst_cnt++;
            if (load_ready && first_ready < 0) first_ready = n;
            if (done) begin
                if (n1 < 0) begin
                    n1 = n;
                    chk("hold_f1_result", result, 1'b1);
                    chk("hold_f1_trace", trace, 32'h0000_001D);
                end else if (n2 < 0) begin
                    n2 = n;
                    chk("hold_f2_result", result, 1'b1);
                    chk("hold_f2_trace", trace, 32'h0000_0007);
                end
            end
            if (n == 12) load_valid = 1'b0;
        end
        load_valid = 1'b0;
        chk("hold_first_ready", first_ready, 11);
        chk("hold_done1", n1, 10);
        chk("hold_done2", n2, 18);
        chk("hold_detrst_cnt", rst_cnt, 2);

        // Asynchronous reset in the middle of a 16-bit frame.
        wait_idle("abort");
        load_valid = 1'b1;
        data_in    = 32'h0000_BBE4;
        len_in     = 6'd16;
        @(posedge clk); #1;
        load_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        chk("abort_pre_x", x, 1'b1);
        chk("abort_pre_trace", trace, 32'h0000_0001);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_x", x, 1'b0);
        chk("abort_detrst", det_rst, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_result", result, 1'b0);
        chk("abort_trace", trace, 32'h0);
        chk("abort_mismatch", mismatch, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        done_cnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        send("after_abort", 6'd8, 32'h0000_0093, 8, 32'h0000_001D, 1'b1, 1'b0);

        // Corrupted 5th response: trace bit for bit 4 flips to 0.
        inv_en = 1'b1;
        send("inv5", 6'd8, 32'h0000_0093, 8, 32'h0000_0015, 1'b1, MIS_EXP);
        inv_en = 1'b0;
        send("post_inv", 6'd4, 32'h0000_000C, 4, 32'h0000_0007, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
